// File: rtl/regfile_wb_arbiter.sv
// Two-source register-file write-back arbiter with a destination scoreboard.
// Define RR_FAIR_EN for round-robin arbitration; otherwise source 0 has fixed priority.
module regfile_wb_arbiter #(
    parameter  int DATA_W = 16,
    parameter  int ADDR_W = 3,
    localparam int NREG   = 2**ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_bar,
    input  logic                     req0_valid,
    input  logic [ADDR_W-1:0]        req0_reg,
    input  logic signed [DATA_W-1:0] req0_value,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [ADDR_W-1:0]        req1_reg,
    input  logic signed [DATA_W-1:0] req1_value,
    output logic                     req1_ready,
    input  logic                     rsv_valid,
    input  logic [ADDR_W-1:0]        rsv_reg,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_regw,
    output logic signed [DATA_W-1:0] rf_regw_value,
    output logic [NREG-1:0]          busy_mask,
    output logic                     rsv_err
);

    typedef struct packed {
        logic [ADDR_W-1:0]        regw;
        logic signed [DATA_W-1:0] value;
    } wb_t;

    logic      grant0, grant1, xfer;
    wb_t       wb_sel;
    logic [NREG-1:0] set_mask, clr_mask;
    localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

`ifdef RR_FAIR_EN
    // prio1 high means source 1 wins the next conflict; flips only on a transfer.
    logic prio1;

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar)  prio1 <= 1'b0;
        else if (xfer) prio1 <= grant0;
    end

    always_comb begin
        grant0 = req0_valid && (!req1_valid || !prio1);
        grant1 = req1_valid && (!req0_valid ||  prio1);
    end
`else
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid && !req0_valid;
    end
`endif

    // Grants are masked by reset so nothing is accepted while rst_bar is low.
    assign req0_ready = rst_bar && grant0;
    assign req1_ready = rst_bar && grant1;
    assign xfer       = req0_ready || req1_ready;

    always_comb begin
        wb_sel = req1_ready ? wb_t'{regw: req1_reg, value: req1_value}
                            : wb_t'{regw: req0_reg, value: req0_value};
    end

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            rf_we         <= 1'b0;
            rf_regw       <= '0;
            rf_regw_value <= '0;
        end else begin
            rf_we <= xfer;
            if (xfer) begin
                rf_regw       <= wb_sel.regw;
                rf_regw_value <= wb_sel.value;
            end
        end
    end

    always_comb begin
        set_mask = rsv_valid ? (ONE_HOT0 << rsv_reg)     : '0;
        clr_mask = xfer      ? (ONE_HOT0 << wb_sel.regw) : '0;
    end

    // Set is applied after clear so a same-edge reserve wins over a write-back.
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            busy_mask <= '0;
            rsv_err   <= 1'b0;
        end else begin
            busy_mask <= (busy_mask & ~clr_mask) | set_mask;
            rsv_err   <= rsv_valid && busy_mask[rsv_reg] && !clr_mask[rsv_reg];
        end
    end

endmodule
